program_encoder_loader: RTL and testbench



---
 rtl/program_encoder_loader.sv | 234 +++++++++++++++++++++++
 tb/tb_program_encoder_loader.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_encoder_loader.sv
// program_encoder_loader
//
// Sequential MIPS instruction encoder and program-memory loader. A load
// session starts with a one-cycle Start pulse that captures the first word
// address and the number of field bundles to accept. Each accepted bundle is
// packed into a 32-bit MIPS word using the same opcode/funct values the
// control unit decodes. The word is then presented as a one-cycle write to
// consecutive instruction-memory locations. Bundles with an illegal Kind are
// consumed without a write and raise a sticky Error flag.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous, active-low reset
//   Start         in   one-cycle request to begin a load session (ignored while Busy)
//   Base_Address  in   first word address, sampled on Start
//   Length        in   number of bundles to accept, sampled on Start
//   In_Valid      in   field bundle valid
//   In_Ready      out  a bundle can be accepted this cycle
//   Kind          in   0=R,1=ADDI,2=ORI,3=ANDI,4=LUI,5=LW,6=SW,7=BEQ,8=BNE,
//                      9=J,10=JAL,11=JR,12..15 illegal
//   Rs/Rt/Rd/Shamt in  register and shift fields
//   Funct         in   funct field (R-type only)
//   Immediate     in   I-type immediate
//   Target        in   J-type target
//   Mem_Write     out  one-cycle write strobe to instruction memory
//   Mem_Address   out  word address (holds when Mem_Write=0)
//   Mem_Data      out  encoded instruction (holds when Mem_Write=0)
//   Busy          out  session in progress (cycle after Start through DRAIN)
//   Done          out  one-cycle end-of-session pulse, aligned with the last write
//   Error         out  sticky illegal-Kind flag, cleared by the next Start

module program_encoder_loader #(
    parameter int MEMORY_DEPTH = 64,
    parameter int ADDR_WIDTH   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Start,
    input  logic [ADDR_WIDTH-1:0] Base_Address,
    input  logic [ADDR_WIDTH:0]   Length,
    input  logic                  In_Valid,
    output logic                  In_Ready,
    input  logic [3:0]            Kind,
    input  logic [4:0]            Rs,
    input  logic [4:0]            Rt,
    input  logic [4:0]            Rd,
    input  logic [4:0]            Shamt,
    input  logic [5:0]            Funct,
    input  logic [15:0]           Immediate,
    input  logic [25:0]           Target,
    output logic                  Mem_Write,
    output logic [ADDR_WIDTH-1:0] Mem_Address,
    output logic [31:0]           Mem_Data,
    output logic                  Busy,
    output logic                  Done,
    output logic                  Error
);

    // ------------------------------------------------------------------
    // Bundle kinds as presented on the Kind input
    // ------------------------------------------------------------------
    localparam logic [3:0] KIND_RTYPE = 4'd0;
    localparam logic [3:0] KIND_ADDI  = 4'd1;
    localparam logic [3:0] KIND_ORI   = 4'd2;
    localparam logic [3:0] KIND_ANDI  = 4'd3;
    localparam logic [3:0] KIND_LUI   = 4'd4;
    localparam logic [3:0] KIND_LW    = 4'd5;
    localparam logic [3:0] KIND_SW    = 4'd6;
    localparam logic [3:0] KIND_BEQ   = 4'd7;
    localparam logic [3:0] KIND_BNE   = 4'd8;
    localparam logic [3:0] KIND_J     = 4'd9;
    localparam logic [3:0] KIND_JAL   = 4'd10;
    localparam logic [3:0] KIND_JR    = 4'd11;

    // ------------------------------------------------------------------
    // Opcode / funct values shared with the control unit decoder
    // ------------------------------------------------------------------
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ORI     = 6'h0d;
    localparam logic [5:0] OP_ANDI    = 6'h0c;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] FUNCT_JR   = 6'h08;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDRESS = ADDR_WIDTH'(MEMORY_DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   ONE_LEFT     = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } loaderStateT;

    loaderStateT           state;
    loaderStateT           nextState;
    logic                  startSession;
    logic                  transfer;
    logic                  kindLegal;
    logic [31:0]           encodedWord;
    logic [ADDR_WIDTH-1:0] addrCount;
    logic [ADDR_WIDTH-1:0] addrCountNext;
    logic [ADDR_WIDTH:0]   remaining;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge value of every other register, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and Moore-style status outputs
    // ------------------------------------------------------------------
    // NOTE: every signal written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        nextState    = state;
        startSession = 1'b0;
        In_Ready     = 1'b0;
        Busy         = 1'b0;
        Done         = 1'b0;
        unique case (state)
            IDLE: begin
                if (Start) begin
                    startSession = 1'b1;
                    nextState    = (Length == '0) ? DRAIN : RUN;
                end
            end
            RUN: begin
                In_Ready = 1'b1;
                Busy     = 1'b1;
                // The final bundle moves us on; the stage register still
                // holds its word, which is presented during DRAIN.
                if (In_Valid && (remaining == ONE_LEFT)) begin
                    nextState = DRAIN;
                end
            end
            DRAIN: begin
                Busy      = 1'b1;
                Done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    assign transfer = In_Valid & In_Ready;

    // ------------------------------------------------------------------
    // Instruction packing
    // ------------------------------------------------------------------
    always_comb begin
        encodedWord = '0;
        kindLegal   = 1'b1;
        case (Kind)
            KIND_RTYPE: encodedWord = {OP_SPECIAL, Rs, Rt, Rd, Shamt, Funct};
            KIND_ADDI:  encodedWord = {OP_ADDI, Rs, Rt, Immediate};
            KIND_ORI:   encodedWord = {OP_ORI,  Rs, Rt, Immediate};
            KIND_ANDI:  encodedWord = {OP_ANDI, Rs, Rt, Immediate};
            // LUI has no source register; the Rs input is deliberately dropped.
            KIND_LUI:   encodedWord = {OP_LUI, 5'b0, Rt, Immediate};
            KIND_LW:    encodedWord = {OP_LW,  Rs, Rt, Immediate};
            KIND_SW:    encodedWord = {OP_SW,  Rs, Rt, Immediate};
            KIND_BEQ:   encodedWord = {OP_BEQ, Rs, Rt, Immediate};
            KIND_BNE:   encodedWord = {OP_BNE, Rs, Rt, Immediate};
            KIND_J:     encodedWord = {OP_J,   Target};
            KIND_JAL:   encodedWord = {OP_JAL, Target};
            KIND_JR:    encodedWord = {OP_SPECIAL, Rs, 15'b0, FUNCT_JR};
            default:    kindLegal   = 1'b0;
        endcase
    end

    // Word address wraps at the memory depth, which need not be a power of two.
    assign addrCountNext = (addrCount == LAST_ADDRESS) ? '0 : addrCount + 1'b1;

    // ------------------------------------------------------------------
    // Session counters
    // ------------------------------------------------------------------
    // NOTE: these two counters carry no reset: they are always loaded by
    // Start before RUN reads them, and reset forces IDLE, so stale values
    // are never observed.
    always_ff @(posedge clk) begin
        if (startSession) begin
            addrCount <= Base_Address;
            remaining <= Length;
        end else if (transfer) begin
            remaining <= remaining - 1'b1;
            // Illegal bundles consume a Length slot but not an address.
            if (kindLegal) begin
                addrCount <= addrCountNext;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage register (memory write port) and sticky error
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            Mem_Write   <= 1'b0;
            Mem_Address <= '0;
            Mem_Data    <= '0;
            Error       <= 1'b0;
        end else begin
            Mem_Write <= transfer & kindLegal;
            // Address and data hold between writes so the memory side
            // sees a stable bus.
            if (transfer && kindLegal) begin
                Mem_Address <= addrCount;
                Mem_Data    <= encodedWord;
            end
            if (startSession) begin
                Error <= 1'b0;
            end else if (transfer && !kindLegal) begin
                Error <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_program_encoder_loader.sv
// Self-checking bench for program_encoder_loader: directed sessions from the
// test plan with literal expectations, then randomized sessions, all compared
// every cycle against a transaction-level reference model.

module tb_program_encoder_loader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          clk;
    logic          reset;
    logic          Start;
    logic [AW-1:0] Base_Address;
    logic [AW:0]   Length;
    logic          In_Valid;
    logic          In_Ready;
    logic [3:0]    Kind;
    logic [4:0]    Rs;
    logic [4:0]    Rt;
    logic [4:0]    Rd;
    logic [4:0]    Shamt;
    logic [5:0]    Funct;
    logic [15:0]   Immediate;
    logic [25:0]   Target;
    logic          Mem_Write;
    logic [AW-1:0] Mem_Address;
    logic [31:0]   Mem_Data;
    logic          Busy;
    logic          Done;
    logic          Error;

    program_encoder_loader #(.MEMORY_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .Start(Start), .Base_Address(Base_Address),
        .Length(Length), .In_Valid(In_Valid), .In_Ready(In_Ready), .Kind(Kind),
        .Rs(Rs), .Rt(Rt), .Rd(Rd), .Shamt(Shamt), .Funct(Funct),
        .Immediate(Immediate), .Target(Target), .Mem_Write(Mem_Write),
        .Mem_Address(Mem_Address), .Mem_Data(Mem_Data), .Busy(Busy),
        .Done(Done), .Error(Error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle  = 0;
    bit checkEn = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: instruction word from the field rules
    // ------------------------------------------------------------------
    function automatic logic [31:0] encodeRef(input int k, input int rs, input int rt,
                                              input int rd, input int sh, input int fn,
                                              input int imm, input int tgt);
        int opTable[12] = '{0, 8, 13, 12, 15, 35, 43, 4, 5, 2, 3, 0};
        logic [31:0] op;
        op = 32'(opTable[k]) << 26;
        if (k == 0)       return (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | (32'(sh) << 6) | 32'(fn);
        else if (k == 4)  return op | (32'(rt) << 16) | 32'(imm);
        else if (k <= 8)  return op | (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm);
        else if (k <= 10) return op | 32'(tgt);
        else              return (32'(rs) << 21) | 32'h8;
    endfunction

    // Expected outputs for the current cycle, plus session bookkeeping.
    bit          expBusy, expReady, expDone, expWrite, expError;
    int          expAddr;
    logic [31:0] expData;
    int          itemsLeft, writeAddr;

    always @(posedge clk) begin
        bit wasBusy, wasReady, wasDone;
        cycle++;
        wasBusy  = expBusy;
        wasReady = expReady;
        wasDone  = expDone;
        expWrite = 1'b0;
        expDone  = 1'b0;
        if (!reset) begin
            expBusy = 0; expReady = 0; expError = 0;
            expAddr = 0; expData = '0; itemsLeft = 0; writeAddr = 0;
        end else if (!wasBusy) begin
            if (Start) begin
                writeAddr = int'(Base_Address);
                itemsLeft = int'(Length);
                expError  = 1'b0;
                expBusy   = 1'b1;
                expReady  = (itemsLeft != 0);
                expDone   = (itemsLeft == 0);
            end
        end else if (wasDone) begin
            expBusy  = 1'b0;
            expReady = 1'b0;
        end else if (wasReady && In_Valid) begin
            itemsLeft--;
            if (int'(Kind) < 12) begin
                expWrite  = 1'b1;
                expAddr   = writeAddr;
                expData   = encodeRef(int'(Kind), int'(Rs), int'(Rt), int'(Rd), int'(Shamt),
                                      int'(Funct), int'(Immediate), int'(Target));
                writeAddr = (writeAddr + 1) % DEPTH;
            end else begin
                expError = 1'b1;
            end
            if (itemsLeft == 0) begin
                expReady = 1'b0;
                expDone  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Compare process and write log
    // ------------------------------------------------------------------
    typedef struct {
        int          addr;
        logic [31:0] data;
        bit          withDone;
        int          cyc;
    } writeRecT;

    writeRecT writeLog[$];

    always @(negedge clk) begin
        if (checkEn) begin
            check("In_Ready",    32'(In_Ready),    32'(expReady));
            check("Busy",        32'(Busy),        32'(expBusy));
            check("Done",        32'(Done),        32'(expDone));
            check("Error",       32'(Error),       32'(expError));
            check("Mem_Write",   32'(Mem_Write),   32'(expWrite));
            check("Mem_Address", 32'(Mem_Address), 32'(expAddr));
            check("Mem_Data",    Mem_Data,         expData);
            if (Mem_Write === 1'b1) begin
                writeLog.push_back('{int'(Mem_Address), Mem_Data, bit'(Done), cycle});
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 2 time units after the rising edge)
    // ------------------------------------------------------------------
    task automatic nextCycle();
        @(posedge clk);
        #2;
    endtask

    task automatic startSession(input int base, input int len);
        Start        = 1'b1;
        Base_Address = AW'(base);
        Length       = (AW + 1)'(len);
        nextCycle();
        Start = 1'b0;
    endtask

    task automatic sendItem(input int k, input int rs, input int rt, input int rd, input int sh,
                            input int fn, input int imm, input int tgt);
        int waited = 0;
        Kind = 4'(k); Rs = 5'(rs); Rt = 5'(rt); Rd = 5'(rd); Shamt = 5'(sh);
        Funct = 6'(fn); Immediate = 16'(imm); Target = 26'(tgt);
        In_Valid = 1'b1;
        while (!expReady && waited < 50) begin
            nextCycle();
            waited++;
        end
        if (!expReady) begin
            checks++;
            errors++;
            $display("FAIL sendItem_timeout: got ready=0 expected ready=1");
        end
        nextCycle();
        In_Valid = 1'b0;
    endtask

    task automatic waitDone(input string name);
        int waited = 0;
        while (Done !== 1'b1 && waited < 20) begin
            nextCycle();
            waited++;
        end
        check(name, 32'(Done), 32'd1);
        nextCycle();
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        reset = 1'b0; Start = 1'b0; Base_Address = '0; Length = '0; In_Valid = 1'b0;
        Kind = '0; Rs = '0; Rt = '0; Rd = '0; Shamt = '0; Funct = '0; Immediate = '0; Target = '0;
        repeat (3) nextCycle();
        checkEn = 1'b1;
        reset   = 1'b1;
        nextCycle();

        // Single ADDI $t0, $zero, 5
        writeLog.delete();
        startSession(0, 1);
        sendItem(1, 0, 8, 0, 0, 0, 5, 0);
        waitDone("addi_done");
        check("addi_count", 32'(writeLog.size()), 32'd1);
        if (writeLog.size() == 1) begin
            check("addi_addr", 32'(writeLog[0].addr), 32'd0);
            check("addi_data", writeLog[0].data, 32'h20080005);
            check("addi_with_done", 32'(writeLog[0].withDone), 32'd1);
        end

        // Back-to-back R-type add, JR $ra, JAL
        writeLog.delete();
        startSession(0, 3);
        sendItem(0, 8, 9, 10, 0, 6'h20, 0, 0);
        sendItem(11, 31, 0, 0, 0, 0, 0, 0);
        sendItem(10, 0, 0, 0, 0, 0, 0, 26'h0100000);
        waitDone("b2b_done");
        check("b2b_count", 32'(writeLog.size()), 32'd3);
        if (writeLog.size() == 3) begin
            check("b2b_data0", writeLog[0].data, 32'h01095020);
            check("b2b_data1", writeLog[1].data, 32'h03E00008);
            check("b2b_data2", writeLog[2].data, 32'h0C100000);
            check("b2b_addr2", 32'(writeLog[2].addr), 32'd2);
            check("b2b_consecutive", 32'(writeLog[2].cyc - writeLog[0].cyc), 32'd2);
        end

        // LUI ignores Rs; BNE with negative offset
        writeLog.delete();
        startSession(5, 2);
        sendItem(4, 5, 1, 0, 0, 0, 16'h1001, 0);
        sendItem(8, 8, 0, 0, 0, 0, 16'hFFFE, 0);
        waitDone("lui_done");
        if (writeLog.size() == 2) begin
            check("lui_data", writeLog[0].data, 32'h3C011001);
            check("bne_data", writeLog[1].data, 32'h1500FFFE);
            check("bne_addr", 32'(writeLog[1].addr), 32'd6);
        end else check("lui_count", 32'(writeLog.size()), 32'd2);

        // Address wrap at the top of memory
        writeLog.delete();
        startSession(62, 3);
        for (int i = 0; i < 3; i++) sendItem(1, 1, 2, 0, 0, 0, i, 0);
        waitDone("wrap_done");
        if (writeLog.size() == 3) begin
            check("wrap_addr0", 32'(writeLog[0].addr), 32'd62);
            check("wrap_addr1", 32'(writeLog[1].addr), 32'd63);
            check("wrap_addr2", 32'(writeLog[2].addr), 32'd0);
        end else check("wrap_count", 32'(writeLog.size()), 32'd3);

        // Illegal kind in the middle of a session
        writeLog.delete();
        startSession(20, 3);
        sendItem(1, 1, 2, 0, 0, 0, 7, 0);
        sendItem(13, 1, 2, 0, 0, 0, 7, 0);
        check("illegal_error_set", 32'(Error), 32'd1);
        check("illegal_no_write", 32'(Mem_Write), 32'd0);
        sendItem(2, 3, 4, 0, 0, 0, 16'h00ff, 0);
        waitDone("illegal_done");
        check("illegal_error_sticky", 32'(Error), 32'd1);
        if (writeLog.size() == 2) begin
            check("illegal_addr0", 32'(writeLog[0].addr), 32'd20);
            check("illegal_addr1", 32'(writeLog[1].addr), 32'd21);
        end else check("illegal_count", 32'(writeLog.size()), 32'd2);
        startSession(0, 0);
        check("zero_len_done", 32'(Done), 32'd1);
        check("error_cleared", 32'(Error), 32'd0);
        nextCycle();

        // Start during RUN is ignored; reset drops the pending write
        writeLog.delete();
        startSession(10, 4);
        Start = 1'b1; Base_Address = AW'(40); Length = (AW + 1)'(1);
        sendItem(1, 1, 1, 0, 0, 0, 1, 0);
        Start = 1'b0;
        sendItem(1, 1, 1, 0, 0, 0, 2, 0);
        Kind = 4'd1; In_Valid = 1'b1; reset = 1'b0;
        nextCycle();
        In_Valid = 1'b0;
        check("rst_write", 32'(Mem_Write), 32'd0);
        check("rst_busy", 32'(Busy), 32'd0);
        check("rst_ready", 32'(In_Ready), 32'd0);
        check("rst_addr", 32'(Mem_Address), 32'd0);
        check("rst_data", Mem_Data, 32'd0);
        reset = 1'b1;
        nextCycle();
        if (writeLog.size() == 2) begin
            check("run_start_addr0", 32'(writeLog[0].addr), 32'd10);
            check("run_start_addr1", 32'(writeLog[1].addr), 32'd11);
        end else check("run_start_count", 32'(writeLog.size()), 32'd2);

        // Randomized sessions against the model
        for (int s = 0; s < 40; s++) begin
            int len, sent, budget;
            bit rdy;
            len = $urandom_range(0, 12);
            startSession($urandom_range(0, DEPTH - 1), len);
            sent = 0;
            budget = 0;
            while (sent < len && budget < 300) begin
                Kind = 4'($urandom_range(0, 15)); Rs = 5'($urandom); Rt = 5'($urandom);
                Rd = 5'($urandom); Shamt = 5'($urandom); Funct = 6'($urandom);
                Immediate = 16'($urandom); Target = 26'($urandom);
                In_Valid = ($urandom_range(0, 3) != 0);
                Start = ($urandom_range(0, 7) == 0);
                Base_Address = AW'($urandom); Length = (AW + 1)'($urandom_range(0, 5));
                rdy = expReady;
                nextCycle();
                if (In_Valid && rdy) sent++;
                budget++;
            end
            In_Valid = 1'b0;
            Start = 1'b0;
            if (sent < len) begin
                checks++;
                errors++;
                $display("FAIL random_session_budget: got %0d items expected %0d", sent, len);
            end
            waitDone("random_done");
            repeat ($urandom_range(0, 2)) nextCycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
